hit_resolver: RTL

Turn and damage controller consuming the projectile's flight/impact signals; the receiving end of the bullet interface. It decides when a shot may be fired, resolves each shot as a hit or a miss, and debits hit points from the struck tank. It also sequences the explosion animation and hands the turn to the other tank. It sits between the bullet block and the top-level sprite/HUD logic, clocked by the frame clock.

---
 rtl/game_pkg.sv | 28 ++
 rtl/frame_timer.sv | 25 ++
 rtl/hit_resolver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the turn/damage controller (hit_resolver).
package game_pkg;

   typedef enum logic [2:0] {
      AIM,
      FLIGHT,
      EXPLODE,
      SWITCH,
      OVER
   } state_t;

   localparam int unsigned HP_W    = 8;
   localparam int unsigned TIMER_W = 9;

   localparam logic [1:0] TANK0 = 2'd0;
   localparam logic [1:0] TANK1 = 2'd1;

   localparam int unsigned DEF_EXPLODE_FRAMES = 30;
   localparam int unsigned DEF_SWITCH_FRAMES  = 60;
   localparam int unsigned DEF_FLIGHT_TIMEOUT = 255;

   // Saturating unsigned debit: never wraps below zero.
   function automatic logic [HP_W-1:0] hp_debit(input logic [HP_W-1:0] hp,
                                                input logic [HP_W-1:0] dmg);
      return (hp > dmg) ? hp - dmg : '0;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done is high while the count sits at zero.
module frame_timer #(
   parameter int unsigned W = 9
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge frame_clk) begin
      if (Reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/hit_resolver.sv
// Turn and damage controller: fire gating, hit/miss resolution, explosion and turn hand-over.
// Optional flight timeout enabled by defining HIT_RESOLVER_FLIGHT_TIMEOUT_EN.
module hit_resolver
   import game_pkg::*;
#(
   parameter int unsigned HP_INIT        = 100,
   parameter int unsigned DAMAGE         = 20,
   parameter int unsigned EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
   parameter int unsigned SWITCH_FRAMES  = DEF_SWITCH_FRAMES,
   parameter int unsigned FLIGHT_TIMEOUT = DEF_FLIGHT_TIMEOUT
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       fire,
   input  logic       bullet_active,
   input  logic       hit,
   input  logic [9:0] BulletX,
   input  logic [9:0] BulletY,
   output logic       fire_enable,
   output logic [1:0] currentTank,
   output logic [7:0] hp_tank0,
   output logic [7:0] hp_tank1,
   output logic       explode_active,
   output logic [9:0] ExplodeX,
   output logic [9:0] ExplodeY,
   output logic [4:0] explode_frame,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam logic [HP_W-1:0] HP_INIT_V = HP_W'(HP_INIT);
   localparam logic [HP_W-1:0] DAMAGE_V  = HP_W'(DAMAGE);

   state_t               state, state_next;
   logic                 bullet_q;
   logic                 timer_load, timer_done;
   logic [TIMER_W-1:0]   timer_val;
   logic                 do_latch, do_hit, do_toggle, do_over;

   frame_timer #(.W(TIMER_W)) u_timer (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (timer_load),
      .load_val  (timer_val),
      .done      (timer_done)
   );

   always_ff @(posedge frame_clk) begin
      if (Reset)
         state <= AIM;
      else
         state <= state_next;
   end

   // Timers are loaded with N-1 on entry so each state spans exactly N frames.
   always_comb begin
      state_next = state;
      timer_load = 1'b0;
      timer_val  = '0;
      do_latch   = 1'b0;
      do_hit     = 1'b0;
      do_toggle  = 1'b0;
      do_over    = 1'b0;
      case (state)
         AIM: begin
            if (fire) begin
               state_next = FLIGHT;
`ifdef HIT_RESOLVER_FLIGHT_TIMEOUT_EN
               timer_load = 1'b1;
               timer_val  = TIMER_W'(FLIGHT_TIMEOUT);
`endif
            end
         end
         FLIGHT: begin
            if (hit) begin
               do_hit     = 1'b1;
               do_latch   = 1'b1;
               state_next = EXPLODE;
               timer_load = 1'b1;
               timer_val  = TIMER_W'(EXPLODE_FRAMES - 1);
            end else if (bullet_q && !bullet_active) begin
               do_latch   = 1'b1;
               state_next = EXPLODE;
               timer_load = 1'b1;
               timer_val  = TIMER_W'(EXPLODE_FRAMES - 1);
            end
`ifdef HIT_RESOLVER_FLIGHT_TIMEOUT_EN
            else if (timer_done) begin
               do_latch   = 1'b1;
               state_next = EXPLODE;
               timer_load = 1'b1;
               timer_val  = TIMER_W'(EXPLODE_FRAMES - 1);
            end
`endif
         end
         EXPLODE: begin
            if (timer_done) begin
               if (hp_tank0 == '0 || hp_tank1 == '0) begin
                  state_next = OVER;
                  do_over    = 1'b1;
               end else begin
                  state_next = SWITCH;
                  timer_load = 1'b1;
                  timer_val  = TIMER_W'(SWITCH_FRAMES - 1);
               end
            end
         end
         SWITCH: begin
            if (timer_done) begin
               state_next = AIM;
               do_toggle  = 1'b1;
            end
         end
         OVER:    state_next = OVER;
         default: state_next = AIM;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         bullet_q      <= 1'b0;
         currentTank   <= TANK0;
         hp_tank0      <= HP_INIT_V;
         hp_tank1      <= HP_INIT_V;
         ExplodeX      <= '0;
         ExplodeY      <= '0;
         explode_frame <= '0;
         winner        <= TANK0;
      end else begin
         bullet_q <= bullet_active;
         if (do_latch) begin
            ExplodeX <= BulletX;
            ExplodeY <= BulletY;
         end
         if (do_hit) begin
            if (currentTank == TANK0)
               hp_tank1 <= hp_debit(hp_tank1, DAMAGE_V);
            else
               hp_tank0 <= hp_debit(hp_tank0, DAMAGE_V);
         end
         if (state == EXPLODE && state_next == EXPLODE)
            explode_frame <= explode_frame + 5'd1;
         else
            explode_frame <= '0;
         if (do_toggle)
            currentTank <= (currentTank == TANK0) ? TANK1 : TANK0;
         if (do_over)
            winner <= currentTank;
      end
   end

   assign fire_enable    = (state == AIM);
   assign explode_active = (state == EXPLODE);
   assign game_over      = (state == OVER);

endmodule
